// File: rtl/wb_dma_arbiter_pkg.sv
// Shared types and helpers for the Wishbone CPU/DMA bus arbiter.
package wb_arb_pkg;

    // Bus ownership phases: CPU owns, CPU detached but finishing, DMA owns
    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_PARK = 2'd1,
        ST_DMA  = 2'd2
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_dma_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = width_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan N slots starting at ptr and latch the first requester seen
    always_comb begin
        int k;
        k     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                valid  = 1'b1;
                idx    = k[IW-1:0];
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_dma_arbiter.sv
// Shares the Wishbone master bus between the CPU (default owner) and NDMA
// DMA masters served round-robin, one whole burst per tenure.
module wb_dma_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NDMA    = 4,
    parameter int AW      = 16,
    parameter int CPU_MIN = 2,
    parameter int TMO     = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AW-1:0]     cpu_adr_i,
    input  logic [15:0]       cpu_dat_i,
    input  logic              cpu_cyc_i,
    input  logic              cpu_stb_i,
    input  logic              cpu_we_i,
    input  logic [1:0]        cpu_sel_i,
    output logic              cpu_gnt_o,
    output logic              cpu_ack_o,
    input  logic [NDMA-1:0]   dma_req_i,
    output logic [NDMA-1:0]   dma_gnt_o,
    input  logic [NDMA*AW-1:0] dma_adr_i,
    input  logic [NDMA*16-1:0] dma_dat_i,
    input  logic [NDMA-1:0]   dma_cyc_i,
    input  logic [NDMA-1:0]   dma_stb_i,
    input  logic [NDMA-1:0]   dma_we_i,
    input  logic [NDMA*2-1:0] dma_sel_i,
    output logic [NDMA-1:0]   dma_ack_o,
    output logic [AW-1:0]     bus_adr_o,
    output logic [15:0]       bus_dat_o,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [1:0]        bus_sel_o,
    input  logic              bus_ack_i,
    output logic              tmo_err_o
);

    localparam int IW = width_of(NDMA);
    localparam int CW = width_of(CPU_MIN + 1);
    localparam int TW = width_of(TMO);

    localparam logic [CW-1:0] CPU_MIN_C = CW'(CPU_MIN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDMA - 1);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cpu_cnt;
    logic [TW-1:0]   idle_cnt;

    logic [NDMA-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    rr_pick #(.N(NDMA), .IW(IW)) u_pick (
        .req   (dma_req_i),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Ownership FSM: CPU slot with minimum length, park until the CPU cycle
    // drains, then one DMA burst ending on release or idle timeout
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_CPU;
            cpu_gnt_o <= 1'b1;
            dma_gnt_o <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            cpu_cnt   <= '0;
            idle_cnt  <= '0;
            tmo_err_o <= 1'b0;
        end else begin
            tmo_err_o <= 1'b0;
            case (state)
                ST_CPU: begin
                    if (cpu_cnt < CPU_MIN_C)
                        cpu_cnt <= cpu_cnt + 1'b1;
                    if ((|dma_req_i) && (cpu_cnt >= CPU_MIN_C)) begin
                        cpu_gnt_o <= 1'b0;
                        state     <= ST_PARK;
                    end
                end
                ST_PARK: begin
                    if (!cpu_cyc_i) begin
                        if (pick_valid) begin
                            dma_gnt_o <= pick_gnt;
                            owner     <= pick_idx;
                            rr_ptr    <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
                            idle_cnt  <= '0;
                            state     <= ST_DMA;
                        end else begin
                            cpu_gnt_o <= 1'b1;
                            state     <= ST_CPU;
                        end
                    end
                end
                ST_DMA: begin
                    if (!(dma_req_i[owner] || dma_cyc_i[owner]) || (idle_cnt == TMO_LAST)) begin
                        dma_gnt_o <= '0;
                        cpu_gnt_o <= 1'b1;
                        cpu_cnt   <= '0;
                        state     <= ST_CPU;
                        tmo_err_o <= (dma_req_i[owner] || dma_cyc_i[owner]);
                    end else if (dma_cyc_i[owner]) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_CPU;
                    cpu_gnt_o <= 1'b1;
                    dma_gnt_o <= '0;
                end
            endcase
        end
    end

    // Bus mux and ack steering from the registered owner; non-owners are cut off
    always_comb begin
        bus_adr_o = cpu_adr_i;
        bus_dat_o = cpu_dat_i;
        bus_cyc_o = cpu_cyc_i;
        bus_stb_o = cpu_stb_i;
        bus_we_o  = cpu_we_i;
        bus_sel_o = cpu_sel_i;
        cpu_ack_o = bus_ack_i;
        dma_ack_o = '0;
        if (state == ST_DMA) begin
            bus_adr_o        = dma_adr_i[int'(owner)*AW +: AW];
            bus_dat_o        = dma_dat_i[int'(owner)*16 +: 16];
            bus_cyc_o        = dma_cyc_i[owner];
            bus_stb_o        = dma_stb_i[owner];
            bus_we_o         = dma_we_i[owner];
            bus_sel_o        = dma_sel_i[int'(owner)*2 +: 2];
            cpu_ack_o        = 1'b0;
            dma_ack_o[owner] = bus_ack_i;
        end
    end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Directed bench for wb_dma_arbiter: reset, grant latency, CPU drain,
// round-robin order, idle timeout and reset during a DMA burst.
module tb_wb_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_dat;
    logic        cpu_cyc;
    logic        cpu_stb;
    logic        cpu_we;
    logic [1:0]  cpu_sel;
    logic        cpu_gnt_o;
    logic        cpu_ack_o;
    logic [3:0]  dma_req;
    logic [3:0]  dma_gnt_o;
    logic [63:0] dma_adr;
    logic [63:0] dma_dat;
    logic [3:0]  dma_cyc;
    logic [3:0]  dma_stb;
    logic [3:0]  dma_we;
    logic [7:0]  dma_sel;
    logic [3:0]  dma_ack_o;
    logic [15:0] bus_adr_o;
    logic [15:0] bus_dat_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [1:0]  bus_sel_o;
    logic        bus_ack;
    logic        tmo_err_o;

    int checks   = 0;
    int failures = 0;

    wb_dma_arbiter #(.NDMA(4), .AW(16), .CPU_MIN(2), .TMO(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_adr_i (cpu_adr),
        .cpu_dat_i (cpu_dat),
        .cpu_cyc_i (cpu_cyc),
        .cpu_stb_i (cpu_stb),
        .cpu_we_i  (cpu_we),
        .cpu_sel_i (cpu_sel),
        .cpu_gnt_o (cpu_gnt_o),
        .cpu_ack_o (cpu_ack_o),
        .dma_req_i (dma_req),
        .dma_gnt_o (dma_gnt_o),
        .dma_adr_i (dma_adr),
        .dma_dat_i (dma_dat),
        .dma_cyc_i (dma_cyc),
        .dma_stb_i (dma_stb),
        .dma_we_i  (dma_we),
        .dma_sel_i (dma_sel),
        .dma_ack_o (dma_ack_o),
        .bus_adr_o (bus_adr_o),
        .bus_dat_o (bus_dat_o),
        .bus_cyc_o (bus_cyc_o),
        .bus_stb_o (bus_stb_o),
        .bus_we_o  (bus_we_o),
        .bus_sel_o (bus_sel_o),
        .bus_ack_i (bus_ack),
        .tmo_err_o (tmo_err_o)
    );

    // Free-running bus clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ccyc, input logic [3:0] req,
                                 input logic [3:0] dcyc, input logic ack);
        cpu_cyc = ccyc;
        cpu_stb = ccyc;
        dma_req = req;
        dma_cyc = dcyc;
        dma_stb = dcyc;
        bus_ack = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_grant(output int hi, output logic seen);
        hi   = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (dma_gnt_o != 4'b0000) seen = 1'b1;
            else if (cpu_gnt_o) hi++;
        end
    endtask

    // Linear directed sequence with hand-computed expectations
    initial begin
        int          hi;
        int          pulses;
        logic        seen;
        logic [3:0]  exp_gnt;
        int          order [5] = '{0, 1, 2, 3, 0};

        cpu_adr = 16'hC0DE;
        cpu_dat = 16'h5A5A;
        cpu_we  = 1'b1;
        cpu_sel = 2'b11;
        dma_adr = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        dma_dat = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        dma_we  = 4'b0000;
        dma_sel = 8'b10_01_11_10;
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Reset held three clocks
        rst = 1'b1;
        tick(); tick(); tick();
        checkOutput("rst_cpu_gnt", cpu_gnt_o, 1);
        checkOutput("rst_dma_gnt", dma_gnt_o, 0);
        checkOutput("rst_tmo", tmo_err_o, 0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("rst_bus_cyc_hi", bus_cyc_o, 1);
        checkOutput("rst_bus_adr", bus_adr_o, 16'hC0DE);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("rst_bus_cyc_lo", bus_cyc_o, 0);
        rst = 1'b0;

        // Grant latency with CPU idle and its minimum slot already served
        tick(); tick(); tick();
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        tick();
        checkOutput("lat_cpu_gnt_clk1", cpu_gnt_o, 0);
        checkOutput("lat_dma_gnt_clk1", dma_gnt_o, 0);
        tick();
        checkOutput("lat_dma_gnt_clk2", dma_gnt_o, 4'b0010);
        applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1);
        #1;
        checkOutput("lat_dma_ack", dma_ack_o, 4'b0010);
        checkOutput("lat_cpu_ack", cpu_ack_o, 0);
        checkOutput("lat_bus_cyc", bus_cyc_o, 1);
        checkOutput("lat_bus_adr", bus_adr_o, 16'h2000);
        checkOutput("lat_bus_dat", bus_dat_o, 16'hD001);
        checkOutput("lat_bus_sel", bus_sel_o, 2'b11);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("rel_cpu_gnt", cpu_gnt_o, 1);
        checkOutput("rel_dma_gnt", dma_gnt_o, 0);

        // CPU cycle in flight when a request rises; rr_ptr is 2 here
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0);
        tick(); tick();
        checkOutput("cpumin_still_cpu", cpu_gnt_o, 1);
        tick();
        checkOutput("park_cpu_gnt", cpu_gnt_o, 0);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1);
        #1;
        checkOutput("park_cpu_ack", cpu_ack_o, 1);
        checkOutput("park_dma_ack", dma_ack_o, 0);
        checkOutput("park_bus_cyc", bus_cyc_o, 1);
        tick();
        checkOutput("park_hold", dma_gnt_o, 0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0);
        tick();
        checkOutput("drain_dma_gnt", dma_gnt_o, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("drain_rel_cpu", cpu_gnt_o, 1);

        // Round-robin from a fresh pointer with all four requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        for (int t = 0; t < 5; t++) begin
            exp_gnt = 4'b0001 << order[t];
            wait_grant(hi, seen);
            checkOutput($sformatf("rr_seen_%0d", t), seen, 1);
            checkOutput($sformatf("rr_gnt_%0d", t), dma_gnt_o, exp_gnt);
            if (t > 0) checkOutput($sformatf("rr_cpu_gap_%0d", t), hi >= 2, 1);
            applyStimulus(1'b0, 4'b1111, exp_gnt, 1'b1);
            #1;
            checkOutput($sformatf("rr_ack_%0d", t), dma_ack_o, exp_gnt);
            checkOutput($sformatf("rr_adr_%0d", t), bus_adr_o, 16'h1000 * (order[t] + 1));
            tick();
            applyStimulus(1'b0, 4'b1111 & ~exp_gnt, 4'b0000, 1'b0);
            tick();
            checkOutput($sformatf("rr_rel_%0d", t), cpu_gnt_o, 1);
            applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        end

        // Master 2 granted but never starts a cycle
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
        wait_grant(hi, seen);
        checkOutput("tmo_gnt", dma_gnt_o, 4'b0100);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (tmo_err_o) pulses++;
        end
        checkOutput("tmo_pulses", pulses, 1);
        checkOutput("tmo_err_at_16", tmo_err_o, 1);
        checkOutput("tmo_dma_gnt", dma_gnt_o, 0);
        checkOutput("tmo_cpu_gnt", cpu_gnt_o, 1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("tmo_one_clock", tmo_err_o, 0);

        // Reset arriving while master 3 is mid-cycle
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0);
        wait_grant(hi, seen);
        checkOutput("mid_gnt", dma_gnt_o, 4'b1000);
        applyStimulus(1'b0, 4'b1000, 4'b1000, 1'b0);
        #1;
        checkOutput("mid_bus_cyc", bus_cyc_o, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_cpu_gnt", cpu_gnt_o, 1);
        checkOutput("mid_rst_dma_gnt", dma_gnt_o, 0);
        checkOutput("mid_rst_bus_cyc", bus_cyc_o, cpu_cyc);
        checkOutput("mid_rst_bus_adr", bus_adr_o, 16'hC0DE);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
